spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receive-side companion to the LIF neuron pair: converts two spike trains (neuron A and neuron B spike outputs) back into numeric firing rates. Counts rising edges on each spike line over a fixed, repeating window of clock cycles and publishes both counts, saturation flags and a winner code with a one-cycle valid strobe. Sits downstream of the neurons, giving the rest of the design a rate-coded readout of the spiking layer.

## Interface

Parameters:
- WINDOW, 16, window length in clock cycles; legal range 2..65536
- CNT_W, 8, width of each rate accumulator and output

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  decode enable; low holds the block idle and aborts any open window
- spike_a  input  1  spike line from neuron A
- spike_b  input  1  spike line from neuron B
- rate_a  output  CNT_W  spike count of A for the last completed window
- rate_b  output  CNT_W  spike count of B for the last completed window
- sat_a  output  1  rate_a saturated in the last completed window
- sat_b  output  1  rate_b saturated in the last completed window
- winner  output  2  01 = A higher, 10 = B higher, 00 = equal, 11 never driven
- valid  output  1  one-cycle strobe: rate/sat/winner updated this cycle

## Operation

- Edge detect: prev_a/prev_b registered every cycle in every state (reset 0); event_x = spike_x & ~prev_x. A line held high counts once; a one-cycle pulse counts once.
- FSM states: IDLE, COUNT.
- IDLE: accumulators and window counter held at 0; events ignored. At an edge with en=1 -> COUNT (acc=0, win_cnt=0).
- COUNT, at each edge:
  - en=0 -> IDLE, accumulators and win_cnt cleared, partial window discarded, no valid, outputs keep previous values.
  - en=1, win_cnt < WINDOW-1: acc_x += event_x (saturating at 2^CNT_W-1, sticky sat bit per channel set on any attempted overflow); win_cnt++.
  - en=1, win_cnt == WINDOW-1: final sum f_x = sat(acc_x + event_x); rate_x <= f_x; sat_x <= sticky bit (incl. this cycle); winner <= compare(f_a, f_b); valid <= 1; acc, sticky bits, win_cnt cleared; stay COUNT (windows back-to-back, no gap).
- valid is 0 in every cycle not following a window close.
- Arithmetic: unsigned; win_cnt width clog2(WINDOW); no wrap on accumulators, saturation only.
- Simultaneous events on A and B in the same cycle both count.

## Timing

- Reset (reset=1 at edge): state IDLE; rate_a=rate_b=0, sat_a=sat_b=0, winner=00, valid=0, prev regs 0. Reset overrides en and any open window.
- en sampled high at edge E0 -> spikes sampled at edges E1..E_WINDOW form window 1 -> valid=1 and new outputs visible after edge E_WINDOW for exactly one cycle.
- Subsequent windows: valid every WINDOW cycles while en stays high.
- Event at edge E0 (IDLE->COUNT transition) is not counted, but prev is updated, so a line already high at E0 is not counted at E1.
- Outputs registered; no combinational path from inputs to outputs.

## Test plan

- Reset: assert reset 2 cycles with en=1 and spikes toggling -> all outputs 0, valid 0; release, en=1 -> first valid exactly WINDOW+1 edges after en first sampled high.
- Rate count (WINDOW=16, CNT_W=8): spike_a one-cycle pulse every 4 cycles, spike_b every 8 -> rate_a=4, rate_b=2, winner=01, sat=0; repeated windows give identical values, valid period 16.
- Held level: spike_a high for entire window, spike_b low, spike_a rising in-window -> rate_a=1, rate_b=0; equal counts on both -> winner=00.
- Saturation (WINDOW=32, CNT_W=3): spike_b toggling every cycle (16 rising edges) -> rate_b=7, sat_b=1; next window with 3 edges -> rate_b=3, sat_b=0.
- Abort: drop en at win_cnt=9 -> no valid, outputs unchanged; re-raise en -> full new window, count excludes pre-abort spikes.
- Reset mid-window: reset at win_cnt=5 with accumulated counts -> outputs 0, IDLE; no valid until a full window after en resampled.

Source files
------------

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spike_rate_decoder                                                         |
// | Counts rising edges on two spike lines over a repeating window and         |
// | publishes both rates, saturation flags and a winner code with a strobe.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spike_rate_decoder #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             spike_a,
  input  logic             spike_b,
  output logic [CNT_W-1:0] rate_a,
  output logic [CNT_W-1:0] rate_b,
  output logic             sat_a,
  output logic             sat_b,
  output logic [1:0]       winner,
  output logic             valid
);

  localparam int c_WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [c_WIN_W-1:0] c_LAST = c_WIN_W'(WINDOW - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               r_prev_a, r_prev_b;
  logic [CNT_W-1:0]   r_acc_a, r_acc_b;
  logic               r_stk_a, r_stk_b;
  logic [c_WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0]   r_rate_a, r_rate_b;
  logic               r_sat_a, r_sat_b;
  logic [1:0]         r_winner;
  logic               r_valid;

  logic               w_ev_a, w_ev_b;
  logic [CNT_W:0]     w_sum_a, w_sum_b;
  logic               w_ovf_a, w_ovf_b;
  logic [CNT_W-1:0]   w_fin_a, w_fin_b;
  logic [1:0]         w_win;
  logic               w_active;
  logic               w_close;

  assign w_ev_a = spike_a & ~r_prev_a;
  assign w_ev_b = spike_b & ~r_prev_b;

  // One extra bit catches the carry so the accumulator clamps instead of wrapping.
  assign w_sum_a = {1'b0, r_acc_a} + {{CNT_W{1'b0}}, w_ev_a};
  assign w_sum_b = {1'b0, r_acc_b} + {{CNT_W{1'b0}}, w_ev_b};
  assign w_ovf_a = w_sum_a[CNT_W];
  assign w_ovf_b = w_sum_b[CNT_W];
  assign w_fin_a = w_ovf_a ? {CNT_W{1'b1}} : w_sum_a[CNT_W-1:0];
  assign w_fin_b = w_ovf_b ? {CNT_W{1'b1}} : w_sum_b[CNT_W-1:0];

  assign w_win = (w_fin_a > w_fin_b) ? 2'b01 :
                 (w_fin_b > w_fin_a) ? 2'b10 : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_close     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_active = 1'b1;
          w_close  = (r_win_cnt == c_LAST);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_a  <= 1'b0;
      r_prev_b  <= 1'b0;
      r_acc_a   <= '0;
      r_acc_b   <= '0;
      r_stk_a   <= 1'b0;
      r_stk_b   <= 1'b0;
      r_win_cnt <= '0;
      r_rate_a  <= '0;
      r_rate_b  <= '0;
      r_sat_a   <= 1'b0;
      r_sat_b   <= 1'b0;
      r_winner  <= 2'b00;
      r_valid   <= 1'b0;
    end else begin
      r_prev_a <= spike_a;
      r_prev_b <= spike_b;
      r_valid  <= 1'b0;
      if (w_close) begin
        r_rate_a  <= w_fin_a;
        r_rate_b  <= w_fin_b;
        r_sat_a   <= r_stk_a | w_ovf_a;
        r_sat_b   <= r_stk_b | w_ovf_b;
        r_winner  <= w_win;
        r_valid   <= 1'b1;
        r_acc_a   <= '0;
        r_acc_b   <= '0;
        r_stk_a   <= 1'b0;
        r_stk_b   <= 1'b0;
        r_win_cnt <= '0;
      end else if (w_active) begin
        r_acc_a   <= w_fin_a;
        r_acc_b   <= w_fin_b;
        r_stk_a   <= r_stk_a | w_ovf_a;
        r_stk_b   <= r_stk_b | w_ovf_b;
        r_win_cnt <= r_win_cnt + c_WIN_W'(1);
      end else begin
        // Idle or aborted window: the partial count is discarded.
        r_acc_a   <= '0;
        r_acc_b   <= '0;
        r_stk_a   <= 1'b0;
        r_stk_b   <= 1'b0;
        r_win_cnt <= '0;
      end
    end
  end

  assign rate_a = r_rate_a;
  assign rate_b = r_rate_b;
  assign sat_a  = r_sat_a;
  assign sat_b  = r_sat_b;
  assign winner = r_winner;
  assign valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spike_rate_decoder                                                      |
// | Directed bench: 16-cycle/8-bit decoder plus a 32-cycle/3-bit instance.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, spike_a, spike_b;
  logic [7:0] rate_a, rate_b;
  logic       sat_a, sat_b, valid;
  logic [1:0] winner;

  logic       s_en, s_a, s_b;
  logic [2:0] s_rate_a, s_rate_b;
  logic       s_sat_a, s_sat_b, s_valid;
  logic [1:0] s_winner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .spike_a(spike_a), .spike_b(spike_b),
    .rate_a(rate_a), .rate_b(rate_b), .sat_a(sat_a), .sat_b(sat_b),
    .winner(winner), .valid(valid)
  );

  spike_rate_decoder #(.WINDOW(32), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .en(s_en), .spike_a(s_a), .spike_b(s_b),
    .rate_a(s_rate_a), .rate_b(s_rate_b), .sat_a(s_sat_a), .sat_b(s_sat_b),
    .winner(s_winner), .valid(s_valid)
  );

  typedef struct {
    int pa;
    int pb;
    int exp_a;
    int exp_b;
    int exp_w;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse pattern: period 0 = silent, 1 = held high, N = one-cycle pulse every N.
  function automatic logic spk(input int k, input int p);
    if (p == 0) return 1'b0;
    return ((k % p) == 0);
  endfunction

  task automatic run_window(input string tag, input int pa, input int pb,
                            input int ea, input int eb, input int ew);
    for (int k = 0; k < 16; k++) begin
      en      = 1'b1;
      spike_a = spk(k, pa);
      spike_b = spk(k, pb);
      tick();
      chk({tag, "_valid"}, int'(valid), (k == 15) ? 1 : 0);
    end
    chk({tag, "_rate_a"}, int'(rate_a), ea);
    chk({tag, "_rate_b"}, int'(rate_b), eb);
    chk({tag, "_winner"}, int'(winner), ew);
    chk({tag, "_sat"}, int'({sat_a, sat_b}), 0);
  endtask

  task automatic run_sat(input string tag, input int mode,
                         input int eb, input int esat);
    for (int k = 0; k < 32; k++) begin
      s_en = 1'b1;
      s_a  = 1'b0;
      case (mode)
        0:       s_b = ((k % 2) == 0);
        1:       s_b = (k == 0) || (k == 10) || (k == 20);
        default: s_b = ((k % 4) == 0) && (k < 28);
      endcase
      tick();
      chk({tag, "_valid"}, int'(s_valid), (k == 31) ? 1 : 0);
    end
    chk({tag, "_rate_b"}, int'(s_rate_b), eb);
    chk({tag, "_sat_b"}, int'(s_sat_b), esat);
    chk({tag, "_rate_a"}, int'(s_rate_a), 0);
    chk({tag, "_sat_a"}, int'(s_sat_a), 0);
    chk({tag, "_winner"}, int'(s_winner), 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{pa: 4, pb: 8, exp_a: 4, exp_b: 2, exp_w: 1};
    vecs[1] = '{pa: 1, pb: 0, exp_a: 1, exp_b: 0, exp_w: 1};
    vecs[2] = '{pa: 8, pb: 8, exp_a: 2, exp_b: 2, exp_w: 0};
    vecs[3] = '{pa: 0, pb: 2, exp_a: 0, exp_b: 8, exp_w: 2};
    vecs[4] = '{pa: 2, pb: 2, exp_a: 8, exp_b: 8, exp_w: 0};
    vecs[5] = '{pa: 0, pb: 0, exp_a: 0, exp_b: 0, exp_w: 0};
    vecs[6] = '{pa: 3, pb: 5, exp_a: 6, exp_b: 4, exp_w: 1};
    vecs[7] = '{pa: 1, pb: 1, exp_a: 1, exp_b: 1, exp_w: 0};

    // Reset with enable high and lines toggling.
    reset = 1'b1; en = 1'b1; spike_a = 1'b0; spike_b = 1'b1;
    s_en = 1'b0; s_a = 1'b0; s_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      spike_a = ~spike_a;
      spike_b = ~spike_b;
      tick();
    end
    chk("rst_rate_a", int'(rate_a), 0);
    chk("rst_rate_b", int'(rate_b), 0);
    chk("rst_sat", int'({sat_a, sat_b}), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_s_valid", int'(s_valid), 0);

    // First strobe: E0 plus WINDOW counting edges.
    reset = 1'b0; en = 1'b1; spike_a = 1'b0; spike_b = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid) begin
        n = i;
        break;
      end
    end
    chk("first_valid_edge", n, 17);
    chk("first_rate_a", int'(rate_a), 0);

    // Back-to-back windows with no gap.
    for (int w = 0; w < 3; w++) begin
      run_window("repeat", 4, 8, 4, 2, 1);
    end

    // Abort after 9 counting edges.
    en = 1'b0; spike_a = 1'b0; spike_b = 1'b0;
    tick();
    chk("abort_idle_valid", int'(valid), 0);
    en = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      spike_a = spk(k, 2);
      tick();
      chk("abort_pre_valid", int'(valid), 0);
    end
    en = 1'b0; spike_a = 1'b0;
    tick();
    chk("abort_valid", int'(valid), 0);
    chk("abort_rate_a", int'(rate_a), 4);
    chk("abort_rate_b", int'(rate_b), 2);
    chk("abort_winner", int'(winner), 1);
    tick();
    en = 1'b1;
    tick();
    run_window("post_abort", 0, 4, 0, 4, 2);

    // Table of single windows, each started fresh from idle.
    foreach (vecs[i]) begin
      en = 1'b0; spike_a = 1'b0; spike_b = 1'b0;
      tick();
      tick();
      en = 1'b1;
      tick();
      run_window($sformatf("vec%0d", i), vecs[i].pa, vecs[i].pb,
                 vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_w);
    end

    // Reset in the middle of a window, line A held high through re-enable.
    en = 1'b0; spike_a = 1'b0; spike_b = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      spike_a = 1'b1;
      spike_b = spk(k, 2);
      tick();
    end
    reset = 1'b1; spike_b = 1'b0;
    tick();
    chk("midrst_rate_a", int'(rate_a), 0);
    chk("midrst_rate_b", int'(rate_b), 0);
    chk("midrst_winner", int'(winner), 0);
    chk("midrst_valid", int'(valid), 0);
    reset = 1'b0;
    tick();
    chk("midrst_e0_valid", int'(valid), 0);
    run_window("held_from_e0", 1, 0, 0, 0, 0);

    // Saturating instance: 16 edges into a 3-bit counter, then 3, then exactly 7.
    en = 1'b0; spike_a = 1'b0;
    s_en = 1'b1; s_b = 1'b0;
    tick();
    run_sat("sat16", 0, 7, 1);
    run_sat("sat3", 1, 3, 0);
    run_sat("sat7", 2, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
